// File: rtl/video_slot_writer.sv
// Slot-bus initiator for a sprite core: uploads a pixel stream into the
// core's sprite RAM and issues position (x0/y0) and bypass register writes.
module video_slot_writer #(
    parameter int CD         = 12,
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH:0]   num_pix,
    input  logic                  pix_valid,
    input  logic [CD-1:0]         pix_data,
    output logic                  pix_ready,
    input  logic                  pos_valid,
    input  logic [10:0]           pos_x,
    input  logic [10:0]           pos_y,
    output logic                  pos_ready,
    input  logic                  byp_valid,
    input  logic                  byp_val,
    output logic                  byp_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  cs,
    output logic                  write,
    output logic [13:0]           addr,
    output logic [31:0]           wr_data
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        FIN,
        POSY
    } state_t;

    localparam logic [ADDR_WIDTH:0] MAX_LEN = {1'b1, {ADDR_WIDTH{1'b0}}};

    localparam logic [13:0] A_BYP = 14'h2000;
    localparam logic [13:0] A_X0  = 14'h2001;
    localparam logic [13:0] A_Y0  = 14'h2002;

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic [ADDR_WIDTH:0]   len_q, len_d;
    logic [10:0]           posy_q, posy_d;
    logic                  cs_q, cs_d;
    logic                  wr_q, wr_d;
    logic [13:0]           addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;

    // Next-state, bus-write and handshake decode
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        len_d     = len_q;
        posy_d    = posy_q;
        cs_d      = 1'b0;
        wr_d      = 1'b0;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        pix_ready = 1'b0;
        pos_ready = 1'b0;
        byp_ready = 1'b0;
        done      = 1'b0;
        busy      = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                // start wins over register requests; position wins over bypass
                pos_ready = ~start & ~reset;
                byp_ready = ~start & ~reset & ~pos_valid;
                if (start) begin
                    if (num_pix == '0) begin
                        state_d = FIN;
                    end else begin
                        len_d   = (num_pix > MAX_LEN) ? MAX_LEN : num_pix;
                        count_d = '0;
                        state_d = LOAD;
                    end
                end else if (pos_valid) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = A_X0;
                    wdata_d = {21'b0, pos_x};
                    posy_d  = pos_y;
                    state_d = POSY;
                end else if (byp_valid) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = A_BYP;
                    wdata_d = {31'b0, byp_val};
                end
            end
            LOAD: begin
                pix_ready = 1'b1;
                if (pix_valid) begin
                    cs_d    = 1'b1;
                    wr_d    = 1'b1;
                    addr_d  = 14'(count_q);
                    wdata_d = 32'(pix_data);
                    count_d = count_q + 1'b1;
                    if ({1'b0, count_q} == len_q - 1'b1) begin
                        state_d = FIN;
                    end
                end
            end
            FIN: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            POSY: begin
                cs_d    = 1'b1;
                wr_d    = 1'b1;
                addr_d  = A_Y0;
                wdata_d = {21'b0, posy_q};
                state_d = IDLE;
            end
        endcase
    end

    // State and registered slot-bus outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            len_q   <= '0;
            posy_q  <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            len_q   <= len_d;
            posy_q  <= posy_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign cs      = cs_q;
    assign write   = wr_q;
    assign addr    = addr_q;
    assign wr_data = wdata_q;

endmodule

// File: tb/tb_video_slot_writer.sv
// Directed bench for video_slot_writer: bitmap uploads, register writes,
// arbitration, full/zero/clamped lengths and reset during an upload.
module tb_video_slot_writer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] num_pix;
    logic        pix_valid;
    logic [11:0] pix_data;
    logic        pix_ready;
    logic        pos_valid;
    logic [10:0] pos_x;
    logic [10:0] pos_y;
    logic        pos_ready;
    logic        byp_valid;
    logic        byp_val;
    logic        byp_ready;
    logic        busy;
    logic        done;
    logic        cs;
    logic        write;
    logic [13:0] addr;
    logic [31:0] wr_data;

    video_slot_writer #(.CD(12), .ADDR_WIDTH(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .num_pix   (num_pix),
        .pix_valid (pix_valid),
        .pix_data  (pix_data),
        .pix_ready (pix_ready),
        .pos_valid (pos_valid),
        .pos_x     (pos_x),
        .pos_y     (pos_y),
        .pos_ready (pos_ready),
        .byp_valid (byp_valid),
        .byp_val   (byp_val),
        .byp_ready (byp_ready),
        .busy      (busy),
        .done      (done),
        .cs        (cs),
        .write     (write),
        .addr      (addr),
        .wr_data   (wr_data)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [13:0] a;
        logic [31:0] d;
        logic        w;
        int          c;
    } wr_t;

    wr_t q[$];
    int  cyc = 0;
    int  done_c = -1;
    int  done_n = 0;
    int  n_chk = 0;
    int  n_fail = 0;
    bit  use_tbl = 1'b1;
    logic [11:0] tbl [4] = '{12'hF00, 12'h0F0, 12'h00F, 12'hFFF};

    always @(posedge clk) cyc <= cyc + 1;

    // Log every bus write and done pulse with the cycle it was seen in
    always @(negedge clk) begin
        if (cs) q.push_back('{addr, wr_data, write, cyc});
        if (done) begin
            done_c = cyc;
            done_n = done_n + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk = n_chk + 1;
        if (got !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [11:0] pixval(input int i);
        if (use_tbl && i < 4) return tbl[i];
        return 12'(i);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic begin_upload(input logic [10:0] n);
        start   = 1'b1;
        num_pix = n;
        tick();
        start   = 1'b0;
    endtask

    // Feed n pixels; toggle=1 drives valid only on even cycles
    task automatic stream(input int n, input bit toggle);
        int  idx = 0;
        int  j = 0;
        bit  hs;
        while (idx < n && j < 4 * n + 20) begin
            pix_valid = toggle ? (j % 2 == 0) : 1'b1;
            pix_data  = pixval(idx);
            hs = pix_valid && pix_ready;
            tick();
            if (hs) idx++;
            j++;
        end
        pix_valid = 1'b0;
        check("stream_accepted", idx, n);
    endtask

    task automatic check_four(input string tag, input int gap);
        check({tag, "_nwr"}, q.size(), 4);
        if (q.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                check({tag, "_addr"}, q[i].a, i);
                check({tag, "_data"}, q[i].d, {20'b0, tbl[i]});
                check({tag, "_we"}, q[i].w, 1);
            end
            check({tag, "_span"}, q[3].c - q[0].c, 3 * gap);
            check({tag, "_done_at"}, done_c, q[3].c);
        end
    endtask

    initial begin
        int n0;
        int errs;
        bit got;
        reset = 1'b1;
        start = 0; num_pix = 0; pix_valid = 0; pix_data = 0;
        pos_valid = 0; pos_x = 0; pos_y = 0;
        byp_valid = 0; byp_val = 0;
        repeat (3) tick();
        check("rst_cs", cs, 0);
        check("rst_addr", addr, 0);
        check("rst_wdata", wr_data, 0);
        check("rst_pos_ready", pos_ready, 0);
        check("rst_byp_ready", byp_ready, 0);
        reset = 1'b0;
        repeat (10) tick();
        check("idle_cs", cs, 0);
        check("idle_write", write, 0);
        check("idle_busy", busy, 0);
        check("idle_done", done, 0);
        check("idle_addr", addr, 0);
        check("idle_nwr", q.size(), 0);

        // held-valid upload of four pixels
        begin_upload(11'd4);
        check("load_busy", busy, 1);
        check("load_pix_ready", pix_ready, 1);
        check("load_pos_ready", pos_ready, 0);
        stream(4, 1'b0);
        check("done_pulse", done, 1);
        tick();
        check("done_once", done, 0);
        check("busy_after", busy, 0);
        check_four("held", 1);
        q.delete();

        // bubbled upload
        begin_upload(11'd4);
        stream(4, 1'b1);
        tick();
        check_four("bubble", 2);
        q.delete();

        // position write pair
        pos_valid = 1; pos_x = 11'd320; pos_y = 11'd240;
        #1;
        check("pos_ready_idle", pos_ready, 1);
        tick();
        pos_valid = 0;
        check("posy_busy", busy, 1);
        check("posy_pos_ready", pos_ready, 0);
        check("x0_addr", addr, 14'h2001);
        check("x0_data", wr_data, 320);
        check("x0_cs", cs, 1);
        tick();
        check("y0_addr", addr, 14'h2002);
        check("y0_data", wr_data, 240);
        check("y0_cs", cs, 1);
        tick();
        check("pos_cs_end", cs, 0);
        check("pos_busy_end", busy, 0);
        q.delete();

        // start beats pending position and bypass requests
        pos_valid = 1; pos_x = 11'd100; pos_y = 11'd200;
        byp_valid = 1; byp_val = 1;
        start = 1; num_pix = 11'd2;
        #1;
        check("arb_pos_ready", pos_ready, 0);
        check("arb_byp_ready", byp_ready, 0);
        tick();
        start = 0;
        check("arb_no_cs", cs, 0);
        check("arb_busy", busy, 1);
        stream(2, 1'b0);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            got = pos_valid && pos_ready;
            if (got) check("arb_byp_masked", byp_ready, 0);
            tick();
        end
        pos_valid = 0;
        check("arb_pos_served", got, 1);
        got = 0;
        for (int k = 0; k < 10 && !got; k++) begin
            got = byp_valid && byp_ready;
            tick();
        end
        byp_valid = 0;
        check("arb_byp_served", got, 1);
        tick();
        check("arb_nwr", q.size(), 5);
        if (q.size() == 5) begin
            check("arb_a0", q[0].a, 14'h0000);
            check("arb_d0", q[0].d, 32'hF00);
            check("arb_a1", q[1].a, 14'h0001);
            check("arb_d1", q[1].d, 32'h0F0);
            check("arb_x0", q[2].a, 14'h2001);
            check("arb_x0d", q[2].d, 100);
            check("arb_y0", q[3].a, 14'h2002);
            check("arb_y0d", q[3].d, 200);
            check("arb_byp", q[4].a, 14'h2000);
            check("arb_bypd", q[4].d, 1);
        end
        q.delete();

        // full-size upload
        use_tbl = 1'b0;
        n0 = done_n;
        begin_upload(11'd1024);
        stream(1024, 1'b0);
        tick();
        check("full_nwr", q.size(), 1024);
        errs = 0;
        foreach (q[i]) if (q[i].a != 14'(i) || q[i].d != 32'(i)) errs++;
        check("full_seq_errs", errs, 0);
        if (q.size() == 1024) check("full_last_addr", q[1023].a, 14'h03FF);
        check("full_done", done_n - n0, 1);
        q.delete();

        // over-range count clamps to the RAM size
        begin_upload(11'd1500);
        stream(1024, 1'b0);
        pix_valid = 1;
        repeat (3) tick();
        pix_valid = 0;
        check("clamp_nwr", q.size(), 1024);
        check("clamp_busy", busy, 0);
        q.delete();

        // zero-length upload
        begin_upload(11'd0);
        check("zero_done", done, 1);
        check("zero_cs", cs, 0);
        tick();
        check("zero_done_end", done, 0);
        check("zero_busy_end", busy, 0);
        check("zero_nwr", q.size(), 0);

        // reset part way through an upload
        begin_upload(11'd1024);
        stream(500, 1'b0);
        check("mid_cs_before", cs, 1);
        check("mid_addr_before", addr, 499);
        @(negedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("mid_cs_drop", cs, 0);
        check("mid_busy_drop", busy, 0);
        tick();
        reset = 1'b0;
        pix_valid = 1;
        repeat (4) tick();
        pix_valid = 0;
        check("mid_idle", busy, 0);
        check("mid_nwr", q.size(), 500);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
